// File: rtl/alu_rs_queue.sv
// alu_rs_queue: integer-ALU reservation station with CDB snooping, oldest-first issue
// and a valid/ready result register.
module alu_rs_queue #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32,
  parameter int ROB_W = 6,
  parameter int NCDB  = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_flush,
  input  logic                         i_disp_valid,
  output logic                         o_disp_ready,
  input  logic [ROB_W-1:0]             i_disp_rob,
  input  logic [6:0]                   i_disp_op,
  input  logic [2:0]                   i_disp_sub,
  input  logic                         i_disp_flag,
  input  logic [XLEN-1:0]              i_disp_d1,
  input  logic [XLEN-1:0]              i_disp_d2,
  input  logic                         i_disp_v1,
  input  logic                         i_disp_v2,
  input  logic [ROB_W-1:0]             i_disp_q1,
  input  logic [ROB_W-1:0]             i_disp_q2,
  input  logic [NCDB-1:0]              i_cdb_valid,
  input  logic [NCDB*ROB_W-1:0]        i_cdb_tag,
  input  logic [NCDB*XLEN-1:0]         i_cdb_data,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic [ROB_W-1:0]             o_out_rob,
  output logic [XLEN-1:0]              o_out_data,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int SW = $clog2(XLEN);

  logic [DEPTH-1:0] r_busy;
  logic [ROB_W-1:0] r_rob [DEPTH];
  logic [2:0]       r_f3 [DEPTH];
  logic             r_flag [DEPTH];
  logic [XLEN-1:0]  r_d1 [DEPTH];
  logic [XLEN-1:0]  r_d2 [DEPTH];
  logic             r_v1 [DEPTH];
  logic             r_v2 [DEPTH];
  logic [ROB_W-1:0] r_q1 [DEPTH];
  logic [ROB_W-1:0] r_q2 [DEPTH];
  logic [IW-1:0]    r_age [DEPTH];
  logic [CW-1:0]    r_count;
  logic             r_out_valid;
  logic [ROB_W-1:0] r_out_rob;
  logic [XLEN-1:0]  r_out_data;

  logic [XLEN:0]    w_s1 [DEPTH];
  logic [XLEN:0]    w_s2 [DEPTH];
  logic [XLEN:0]    w_b1, w_b2;
  logic             w_hit, w_issue, w_alloc;
  logic [IW-1:0]    w_sel, w_sel_age, w_free, w_new_age;
  logic [XLEN-1:0]  w_res;

  // Returns {valid, data}; the lowest matching CDB port wins.
  function automatic logic [XLEN:0] snoop(input logic v, input logic [ROB_W-1:0] q,
                                          input logic [XLEN-1:0] d);
    snoop = {v, d};
    for (int k = NCDB-1; k >= 0; k--)
      if (!v && i_cdb_valid[k] && i_cdb_tag[k*ROB_W +: ROB_W] == q)
        snoop = {1'b1, i_cdb_data[k*XLEN +: XLEN]};
  endfunction

  function automatic logic [XLEN-1:0] alu(input logic [2:0] f, input logic fl,
                                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [SW-1:0]   sh;
    logic [XLEN-1:0] sra;
    sh  = b[SW-1:0];
    sra = $signed(a) >>> sh;
    case (f)
      3'b000:  alu = fl ? a - b : a + b;
      3'b001:  alu = a << sh;
      3'b010:  alu = XLEN'($signed(a) < $signed(b));
      3'b011:  alu = XLEN'(a < b);
      3'b100:  alu = a ^ b;
      3'b101:  alu = fl ? sra : a >> sh;
      3'b110:  alu = a | b;
      default: alu = a & b;
    endcase
  endfunction

  always_comb begin
    w_hit     = 1'b0;
    w_sel     = '0;
    w_sel_age = '0;
    w_free    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_s1[i] = snoop(r_v1[i], r_q1[i], r_d1[i]);
      w_s2[i] = snoop(r_v2[i], r_q2[i], r_d2[i]);
      if (r_busy[i] && r_v1[i] && r_v2[i] && (!w_hit || r_age[i] < w_sel_age)) begin
        w_hit     = 1'b1;
        w_sel     = IW'(i);
        w_sel_age = r_age[i];
      end
    end
    for (int i = DEPTH-1; i >= 0; i--)
      if (!r_busy[i]) w_free = IW'(i);
    w_b1      = snoop(i_disp_v1, i_disp_q1, i_disp_d1);
    w_b2      = snoop(i_disp_v2, i_disp_q2, i_disp_d2);
    w_issue   = w_hit && (!r_out_valid || i_out_ready);
    w_alloc   = i_disp_valid && o_disp_ready && !i_flush &&
                (i_disp_op == 7'b0110011 || i_disp_op == 7'b0010011);
    w_new_age = IW'(r_count - CW'(w_issue));
    w_res     = alu(r_f3[w_sel], r_flag[w_sel], r_d1[w_sel], r_d2[w_sel]);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy      <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_rob   <= '0;
      r_out_data  <= '0;
    end else if (i_flush) begin
      r_busy      <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_issue) r_busy[w_sel] <= 1'b0;
      if (w_alloc) r_busy[w_free] <= 1'b1;
      r_count <= r_count + CW'(w_alloc) - CW'(w_issue);
      if (w_issue) begin
        r_out_valid <= 1'b1;
        r_out_rob   <= r_rob[w_sel];
        r_out_data  <= w_res;
      end else if (i_out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Entry payload needs no reset: it is only observed while its busy bit is set.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_alloc && w_free == IW'(i)) begin
        r_rob[i]            <= i_disp_rob;
        r_f3[i]             <= i_disp_sub;
        r_flag[i]           <= i_disp_flag;
        {r_v1[i], r_d1[i]}  <= w_b1;
        {r_v2[i], r_d2[i]}  <= w_b2;
        r_q1[i]             <= i_disp_q1;
        r_q2[i]             <= i_disp_q2;
        r_age[i]            <= w_new_age;
      end else begin
        {r_v1[i], r_d1[i]}  <= w_s1[i];
        {r_v2[i], r_d2[i]}  <= w_s2[i];
        if (w_issue && r_age[i] > w_sel_age) r_age[i] <= r_age[i] - 1'b1;
      end
    end
  end

  assign o_disp_ready = r_count < CW'(DEPTH);
  assign o_out_valid  = r_out_valid;
  assign o_out_rob    = r_out_rob;
  assign o_out_data   = r_out_data;
  assign o_count      = r_count;
endmodule

// File: tb/tb_alu_rs_queue.sv
// tb_alu_rs_queue: directed stimulus with a result scoreboard popped by an output monitor.
module tb_alu_rs_queue;
  localparam logic [6:0] OP_R = 7'h33;
  localparam logic [6:0] OP_I = 7'h13;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        disp_valid = 1'b0;
  logic        disp_ready;
  logic [5:0]  disp_rob = '0;
  logic [6:0]  disp_op = '0;
  logic [2:0]  disp_sub = '0;
  logic        disp_flag = 1'b0;
  logic [31:0] disp_d1 = '0, disp_d2 = '0;
  logic        disp_v1 = 1'b0, disp_v2 = 1'b0;
  logic [5:0]  disp_q1 = '0, disp_q2 = '0;
  logic [1:0]  cdb_valid = '0;
  logic [11:0] cdb_tag = '0;
  logic [63:0] cdb_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [5:0]  out_rob;
  logic [31:0] out_data;
  logic [3:0]  count;

  int n_tests = 0;
  int n_fail = 0;
  logic [37:0] sb[$];

  typedef struct {logic [6:0] op; logic [2:0] f3; logic fl; logic [31:0] a, b, e;} vec_t;
  vec_t vt[10];

  alu_rs_queue dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_disp_valid(disp_valid), .o_disp_ready(disp_ready), .i_disp_rob(disp_rob),
    .i_disp_op(disp_op), .i_disp_sub(disp_sub), .i_disp_flag(disp_flag),
    .i_disp_d1(disp_d1), .i_disp_d2(disp_d2), .i_disp_v1(disp_v1), .i_disp_v2(disp_v2),
    .i_disp_q1(disp_q1), .i_disp_q2(disp_q2),
    .i_cdb_valid(cdb_valid), .i_cdb_tag(cdb_tag), .i_cdb_data(cdb_data),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_rob(out_rob),
    .o_out_data(out_data), .o_count(count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      logic [37:0] e;
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got rob=%0d data=%h, nothing expected", out_rob, out_data);
      end else begin
        e = sb.pop_front();
        if ({out_rob, out_data} !== e) begin
          n_fail++;
          $display("FAIL result: got rob=%0d data=%h, expected rob=%0d data=%h",
                   out_rob, out_data, e[37:32], e[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic push(input logic [5:0] rob, input logic [31:0] data);
    sb.push_back({rob, data});
  endtask

  task automatic disp(input logic [5:0] rob, input logic [6:0] op, input logic [2:0] f3,
                      input logic fl, input logic [31:0] a, input logic va, input logic [5:0] qa,
                      input logic [31:0] b, input logic vb, input logic [5:0] qb);
    disp_rob = rob; disp_op = op; disp_sub = f3; disp_flag = fl;
    disp_d1 = a; disp_v1 = va; disp_q1 = qa;
    disp_d2 = b; disp_v2 = vb; disp_q2 = qb;
    disp_valid = 1'b1;
    tick();
    disp_valid = 1'b0;
  endtask

  task automatic cdb(input int p, input logic [5:0] tag, input logic [31:0] data);
    cdb_valid[p] = 1'b1;
    cdb_tag[p*6 +: 6] = tag;
    cdb_data[p*32 +: 32] = data;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
    tick();
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    vt[0] = '{OP_R, 3'b010, 1'b0, 32'hFFFFFFFF, 32'h1, 32'h1};
    vt[1] = '{OP_R, 3'b011, 1'b0, 32'hFFFFFFFF, 32'h1, 32'h0};
    vt[2] = '{OP_R, 3'b101, 1'b1, 32'h80000000, 32'h21, 32'hC0000000};
    vt[3] = '{OP_R, 3'b101, 1'b0, 32'h80000000, 32'h21, 32'h40000000};
    vt[4] = '{OP_I, 3'b001, 1'b0, 32'h1, 32'h21, 32'h2};
    vt[5] = '{OP_R, 3'b100, 1'b0, 32'hF0F0, 32'hFF00, 32'h0FF0};
    vt[6] = '{OP_I, 3'b110, 1'b0, 32'hF0F0, 32'h0F00, 32'hFFF0};
    vt[7] = '{OP_R, 3'b111, 1'b0, 32'hF0F0, 32'hFF00, 32'hF000};
    vt[8] = '{OP_R, 3'b000, 1'b1, 32'h0, 32'h1, 32'hFFFFFFFF};
    vt[9] = '{OP_I, 3'b000, 1'b0, 32'hFFFFFFFF, 32'h2, 32'h1};

    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_rob", 64'(out_rob), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_disp_ready", 64'(disp_ready), 64'd1);
    rst_n = 1'b1;
    tick();

    push(3, 12);
    disp(3, OP_R, 3'b000, 0, 5, 1, 0, 7, 1, 0);
    check("add_latency", 64'(out_valid), 64'd0);
    check("add_count1", 64'(count), 64'd1);
    tick();
    check("add_valid", 64'(out_valid), 64'd1);
    check("add_count0", 64'(count), 64'd0);
    drain();

    push(5, 32'h0F);
    disp(5, OP_R, 3'b000, 1, 0, 0, 9, 1, 1, 0);
    cdb(1, 9, 32'h10);
    tick();
    cdb_valid = '0;
    check("sub_wake_wait", 64'(out_valid), 64'd0);
    tick();
    check("sub_wake_valid", 64'(out_valid), 64'd1);
    drain();

    push(6, 32'h0F);
    cdb(1, 9, 32'h10);
    disp(6, OP_R, 3'b000, 1, 0, 0, 9, 1, 1, 0);
    cdb_valid = '0;
    check("sub_byp_wait", 64'(out_valid), 64'd0);
    tick();
    check("sub_byp_valid", 64'(out_valid), 64'd1);
    drain();

    push(7, 200);
    disp(7, OP_R, 3'b000, 0, 0, 0, 2, 0, 0, 2);
    cdb(0, 2, 100);
    cdb(1, 2, 300);
    tick();
    cdb_valid = '0;
    drain();

    for (int i = 0; i < 8; i++) begin
      push(6'(i), 32'h20 + i);
      disp(6'(i), OP_R, 3'b000, 0, 0, 0, 4, 32'(i), 1, 0);
    end
    check("full_count", 64'(count), 64'd8);
    check("full_ready", 64'(disp_ready), 64'd0);
    cdb(0, 4, 32'h20);
    disp_rob = 9; disp_op = OP_R; disp_sub = 0; disp_flag = 0;
    disp_v1 = 1; disp_v2 = 1; disp_d1 = 1; disp_d2 = 1;
    disp_valid = 1'b1;
    tick();
    cdb_valid = '0;
    check("full_wake_count", 64'(count), 64'd8);
    check("full_wake_ready", 64'(disp_ready), 64'd0);
    tick();
    disp_valid = 1'b0;
    check("full_issue_count", 64'(count), 64'd7);
    check("full_issue_ready", 64'(disp_ready), 64'd1);
    drain();

    push(20, 2);
    push(21, 32'h41);
    push(22, 32'h42);
    disp(20, OP_R, 3'b000, 0, 1, 1, 0, 1, 1, 0);
    disp(21, OP_R, 3'b000, 0, 0, 0, 11, 1, 1, 0);
    disp(22, OP_R, 3'b000, 0, 0, 0, 11, 2, 1, 0);
    cdb(0, 11, 32'h40);
    tick();
    cdb_valid = '0;
    drain();

    out_ready = 1'b0;
    push(1, 3);
    push(2, 7);
    disp(1, OP_R, 3'b000, 0, 1, 1, 0, 2, 1, 0);
    disp(2, OP_R, 3'b000, 0, 3, 1, 0, 4, 1, 0);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_rob", 64'(out_rob), 64'd1);
      check("bp_data", 64'(out_data), 64'd3);
      check("bp_count", 64'(count), 64'd1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp_next_valid", 64'(out_valid), 64'd1);
    check("bp_next_rob", 64'(out_rob), 64'd2);
    drain();

    for (int i = 0; i < 10; i++) begin
      push(6'(40 + i), vt[i].e);
      disp(6'(40 + i), vt[i].op, vt[i].f3, vt[i].fl, vt[i].a, 1, 0, vt[i].b, 1, 0);
    end
    drain();

    disp(50, 7'b0000011, 3'b000, 0, 1, 1, 0, 1, 1, 0);
    check("badop_count", 64'(count), 64'd0);
    drain();

    out_ready = 1'b0;
    disp(60, OP_R, 3'b000, 0, 1, 1, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) disp(6'(61 + i), OP_R, 3'b000, 0, 0, 0, 30, 1, 1, 0);
    check("pre_flush_count", 64'(count), 64'd3);
    check("pre_flush_valid", 64'(out_valid), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_count", 64'(count), 64'd0);
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_ready", 64'(disp_ready), 64'd1);
    out_ready = 1'b1;
    cdb(0, 30, 5);
    tick();
    cdb_valid = '0;
    tick(); tick(); tick();
    check("flush_no_output", 64'(out_valid), 64'd0);

    out_ready = 1'b0;
    disp(15, OP_R, 3'b000, 0, 2, 1, 0, 3, 1, 0);
    disp(16, OP_R, 3'b000, 0, 0, 0, 33, 1, 1, 0);
    check("prerst_rob", 64'(out_rob), 64'd15);
    check("prerst_count", 64'(count), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_rob", 64'(out_rob), 64'd0);
    check("arst_data", 64'(out_data), 64'd0);
    check("arst_count", 64'(count), 64'd0);
    check("arst_ready", 64'(disp_ready), 64'd1);
    #4 rst_n = 1'b1;
    out_ready = 1'b1;
    tick(); tick();
    check("post_rst_valid", 64'(out_valid), 64'd0);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_rs_queue.md
# alu_rs_queue

Parametrised integer-ALU reservation station sitting between the dispatch stage and the CDB/ROB writeback path. It holds up to DEPTH in-flight R-type/I-type ALU operations and snoops NCDB common-data-bus ports for pending operands. Each cycle it issues the oldest entry with both operands ready, computes the result, and presents it on a valid/ready output register for CDB arbitration. It replaces the fixed 4-entry station, adding configurable depth, configurable CDB port count, dispatch-time CDB bypass, flush, output backpressure and oldest-first selection.

## Interface
- DEPTH, 8, entry count (2..32)
- XLEN, 32, operand/result width (32 or 64)
- ROB_W, 6, ROB tag width
- NCDB, 2, number of snooped CDB ports (1..4)
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous squash of all entries and the output register
- disp_valid  in  1  dispatch request
- disp_ready  out  1  `count < DEPTH`
- disp_rob  in  ROB_W  destination ROB tag
- disp_op  in  7  opcode: 0110011 (R) or 0010011 (I)
- disp_sub  in  3  funct3
- disp_flag  in  1  selects SUB (funct3 000) or SRA (funct3 101)
- disp_d1, disp_d2  in  XLEN  operand values
- disp_v1, disp_v2  in  1  operand already valid
- disp_q1, disp_q2  in  ROB_W  producer tags, used when the matching v bit is 0
- cdb_valid  in  NCDB  per-port broadcast valid
- cdb_tag  in  NCDB*ROB_W  per-port tag; port k occupies bits [k*ROB_W +: ROB_W]
- cdb_data  in  NCDB*XLEN  per-port data; port k occupies bits [k*XLEN +: XLEN]
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts the result
- out_rob  out  ROB_W  tag of the result
- out_data  out  XLEN  result value
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Entry fields: busy, rob, funct3, flag, d1/v1/q1, d2/v2/q2, and an age rank.
- Allocation happens on a handshake `disp_valid && disp_ready && !flush` when disp_op is one of the two ALU opcodes. Any other opcode is consumed with no entry and no output.
  - The new entry goes to the lowest-index free slot.
  - It receives the youngest age rank.
- Dispatch bypass: if an operand has v=0 and cdb_valid[k] is set with cdb_tag[k]==q in the same cycle, the entry is written with v=1 and the data from port k.
- Wakeup: every busy entry with v=0 on an operand and a matching valid CDB port captures that port's data and sets v=1.
  - If several ports match, the lowest port index wins.
  - Both operands may wake in the same cycle, including from the same port.
- Issue eligibility: the entry is busy with v1 and v2 both set, and the output register is empty or is being drained this cycle (`out_ready`).
  - Among eligible entries, the oldest is issued.
  - The issued entry is freed, and the remaining age ranks compact.
- ALU functions (a=d1, b=d2, sh=b[$clog2(XLEN)-1:0]):
  - 000: a+b, or a-b when flag=1
  - 001: a<<sh
  - 010: signed a<b → 1 else 0
  - 011: unsigned a<b → 1 else 0
  - 100: a^b
  - 101: a>>sh, or arithmetic a>>>sh when flag=1
  - 110: a|b
  - 111: a&b
  - Results wrap modulo 2^XLEN.
- Output register: out_valid, out_rob and out_data stay stable until `out_valid && out_ready`.
- Flush has top priority. At the edge it clears every busy bit, clears out_valid and sets count=0. Dispatch and issue in that cycle are discarded.
- count = busy entries, not including the output register.

## Timing
- Reset values: disp_ready=1, out_valid=0, out_rob=0, out_data=0, count=0, all busy=0.
- Reset is asynchronous on assert and released synchronously in the clock domain.
- Minimum latency: an operand-ready dispatch at edge E0 becomes out_valid after edge E1.
- Wakeup: a CDB broadcast at edge E makes the entry eligible for issue at edge E+1. Because of bypass, a broadcast in the dispatch cycle behaves identically.
- disp_ready depends only on the registered count. A slot freed by issue in the same cycle is not reusable until the next cycle, so a full station with a simultaneous issue still has disp_ready=0.
- Throughput: one issue per cycle while out_ready=1.
- Backpressure: with out_ready=0 and out_valid=1, no issue occurs and entries keep waking.

## Test plan
- Dispatch ADD d1=5, d2=7, v1=v2=1, rob=3, out_ready=1 → out_valid one cycle later, out_rob=3, out_data=12, count returns to 0.
- Dispatch SUB flag=1, q1=9, v1=0, d2=1; at the next cycle cdb port 1 drives tag 9, data 0x10 → out_data=0x0F two cycles after the broadcast. Repeat with the broadcast in the dispatch cycle → result one cycle after dispatch.
- Fill all 8 entries with v1=0 on a common tag 4 → disp_ready=0 and count=8. Broadcast tag 4 → issues in dispatch order (rob 0..7), one per cycle. disp_ready rises the cycle after the first issue.
- Hold out_ready=0 with two ready entries → out_valid=1 with the first result held stable for 5 cycles and count=1. Release out_ready → the second result follows on the next cycle.
- Signed compare and shifts: SLT 0xFFFFFFFF<1 → 1; SLTU → 0; SRA flag=1 of 0x80000000 by b=0x21 → 0xC0000000 (shift amount 1).
- Assert flush with 3 busy entries and out_valid=1 → next cycle count=0 and out_valid=0, and later CDB broadcasts produce no output. Assert reset mid-operation → all outputs return to their reset values immediately.
